// File: rtl/dbg_hex_tx.sv
// Debug UART transmitter: renders a latched 16-bit word as four uppercase hex digits plus CR LF,
// 8N1, LSB first. One request per line; requests while busy are dropped.
module dbg_hex_tx #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 1_000_000
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        start_i,
    input  logic [15:0] data_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("dbg_hex_tx: CLK_FREQ / BAUD must be at least 2");
    end

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e           r_state, w_state;
    logic [CNT_W-1:0] r_baud, w_baud;
    logic [2:0]       r_bit, w_bit;
    logic [2:0]       r_char, w_char_idx;
    logic [15:0]      r_word, w_word;
    logic             r_tx, w_tx;
    logic             r_busy, w_busy;
    logic             r_done, w_done;

    logic [7:0]       w_char;
    logic             w_bit_end;
    logic [2:0]       w_next_bit;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        // 'A' - 10 = 0x37
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_comb begin
        case (r_char)
            3'd0:    w_char = hex_ascii(r_word[15:12]);
            3'd1:    w_char = hex_ascii(r_word[11:8]);
            3'd2:    w_char = hex_ascii(r_word[7:4]);
            3'd3:    w_char = hex_ascii(r_word[3:0]);
            3'd4:    w_char = 8'h0D;
            default: w_char = 8'h0A;
        endcase
    end

    assign w_bit_end  = (r_baud == BAUD_LAST);
    assign w_next_bit = r_bit + 3'd1;

    always_comb begin
        w_state    = r_state;
        w_baud     = r_baud;
        w_bit      = r_bit;
        w_char_idx = r_char;
        w_word     = r_word;
        w_tx       = r_tx;
        w_busy     = r_busy;
        w_done     = 1'b0;

        case (r_state)
            StIdle: begin
                w_tx   = 1'b1;
                w_busy = 1'b0;
                if (start_i) begin
                    w_state    = StStart;
                    w_word     = data_i;
                    w_baud     = '0;
                    w_bit      = '0;
                    w_char_idx = '0;
                    w_tx       = 1'b0;
                    w_busy     = 1'b1;
                end
            end
            StStart: begin
                if (w_bit_end) begin
                    w_baud  = '0;
                    w_state = StData;
                    w_tx    = w_char[0];
                end else begin
                    w_baud = r_baud + CNT_W'(1);
                end
            end
            StData: begin
                if (w_bit_end) begin
                    w_baud = '0;
                    if (r_bit == 3'd7) begin
                        w_state = StStop;
                        w_bit   = '0;
                        w_tx    = 1'b1;
                    end else begin
                        w_bit = w_next_bit;
                        w_tx  = w_char[w_next_bit];
                    end
                end else begin
                    w_baud = r_baud + CNT_W'(1);
                end
            end
            StStop: begin
                if (w_bit_end) begin
                    w_baud = '0;
                    if (r_char == 3'd5) begin
                        w_state = StIdle;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_tx    = 1'b1;
                    end else begin
                        // Next start bit follows the stop bit with no idle gap.
                        w_char_idx = r_char + 3'd1;
                        w_state    = StStart;
                        w_tx       = 1'b0;
                    end
                end else begin
                    w_baud = r_baud + CNT_W'(1);
                end
            end
            default: begin
                w_state = StIdle;
                w_tx    = 1'b1;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= StIdle;
            r_baud  <= '0;
            r_bit   <= '0;
            r_char  <= '0;
            r_word  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_baud  <= w_baud;
            r_bit   <= w_bit;
            r_char  <= w_char_idx;
            r_word  <= w_word;
            r_tx    <= w_tx;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    assign tx_o   = r_tx;
    assign busy_o = r_busy;
    assign done_o = r_done;

endmodule

// File: tb/tb_dbg_hex_tx.sv
// Scoreboard bench for dbg_hex_tx: stimulus pushes expected bytes, a UART monitor decodes tx_o
// on falling clock edges and pops/compares each received character.
module tb_dbg_hex_tx;

    localparam int C = 100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data = 16'h0000;
    logic        tx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    int starts_q[$];
    logic mon_busy = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dbg_hex_tx #(
        .CLK_FREQ(100_000_000),
        .BAUD    (1_000_000)
    ) dut (
        .clk_i   (clk),
        .reset_ni(reset_n),
        .start_i (start),
        .data_i  (data),
        .tx_o    (tx),
        .busy_o  (busy),
        .done_o  (done)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // UART receiver: every sample of a bit window must match its first sample.
    initial begin : monitor
        logic [9:0] bits;
        logic       stable;
        logic       abort;
        bits = '0;
        forever begin
            @(negedge clk);
            if (reset_n && tx === 1'b0) begin
                mon_busy = 1'b1;
                starts_q.push_back(cyc);
                abort  = 1'b0;
                stable = 1'b1;
                for (int b = 0; b < 10 && !abort; b++) begin
                    for (int k = 0; k < C && !abort; k++) begin
                        if (!(b == 0 && k == 0)) @(negedge clk);
                        if (!reset_n) abort = 1'b1;
                        else if (k == 0) bits[b] = tx;
                        else if (tx !== bits[b]) stable = 1'b0;
                    end
                end
                if (!abort) begin
                    check("bit_period_stable", int'(stable), 1);
                    check("stop_bit", int'(bits[9]), 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_char: got 0x%0h, expected no character", bits[8:1]);
                    end else begin
                        check("char", int'(bits[8:1]), int'(exp_q.pop_front()));
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_line(input logic [47:0] v);
        for (int i = 0; i < 6; i++) exp_q.push_back(v[47-8*i -: 8]);
    endtask

    // Leaves start high; returns at the negedge right after the accepting edge.
    task automatic accept(input string tag, input logic [15:0] d);
        @(negedge clk);
        check({tag, "_tx_idle"}, int'(tx), 1);
        check({tag, "_busy_idle"}, int'(busy), 0);
        start = 1'b1;
        data  = d;
        @(negedge clk);
        check({tag, "_tx_startbit"}, int'(tx), 0);
        check({tag, "_busy_rise"}, int'(busy), 1);
    endtask

    // Called at the first busy negedge; returns one cycle after the done pulse.
    task automatic finish_line(input string tag);
        int n;
        n = 1;
        @(negedge clk);
        while (busy === 1'b1 && n < 7000) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_len"}, n, 60 * C);
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_tx_end"}, int'(tx), 1);
        @(negedge clk);
        check({tag, "_done_single"}, int'(done), 0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((mon_busy || exp_q.size() != 0) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin : stimulus
        int base;
        int n;
        int high_ok;

        repeat (3) @(negedge clk);
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        reset_n = 1'b1;

        // Basic line
        accept("basic", 16'h0003);
        start = 1'b0;
        push_line(48'h303030330D0A);
        finish_line("basic");
        drain("basic");

        // Hex letters; data_i changes one cycle after acceptance
        accept("hex", 16'hBEEF);
        data  = 16'h1234;
        start = 1'b0;
        push_line(48'h424545460D0A);
        finish_line("hex");
        drain("hex");

        // start_i held high: second line accepted in the done cycle
        accept("hold1", 16'h5A3C);
        data = 16'h0C07;
        push_line(48'h354133430D0A);
        push_line(48'h304330370D0A);
        finish_line("hold1");
        check("hold_restart_busy", int'(busy), 1);
        check("hold_restart_tx", int'(tx), 0);
        start = 1'b0;
        finish_line("hold2");
        drain("hold");

        // Extra pulses mid-line are ignored
        accept("extra", 16'h9F1D);
        start = 1'b0;
        push_line(48'h394631440D0A);
        fork
            begin
                repeat (1500) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (2100) @(negedge clk);
                start = 1'b1;
                repeat (5) @(negedge clk);
                start = 1'b0;
            end
        join_none
        finish_line("extra");
        drain("extra");

        // Reset during DATA of char 2
        base = starts_q.size();
        accept("rst", 16'h1234);
        start = 1'b0;
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h32);
        n = 0;
        while (starts_q.size() < base + 3 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check("rst_char2_started", starts_q.size(), base + 3);
        repeat (300) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_tx", int'(tx), 1);
        check("rst_async_busy", int'(busy), 0);
        repeat (4) @(negedge clk);
        check("rst_hold_tx", int'(tx), 1);
        reset_n = 1'b1;
        start   = 1'b1;
        data    = 16'hA5F0;
        push_line(48'h413546300D0A);
        @(negedge clk);
        check("rst_first_edge_tx", int'(tx), 0);
        check("rst_first_edge_busy", int'(busy), 1);
        start = 1'b0;
        finish_line("rst");
        drain("rst");

        // Frame timing for 0x0000
        base = starts_q.size();
        accept("frame", 16'h0000);
        start = 1'b0;
        push_line(48'h303030300D0A);
        finish_line("frame");
        drain("frame");
        check("frame_count", starts_q.size(), base + 6);
        if (starts_q.size() >= base + 6) begin
            for (int i = 1; i < 6; i++) begin
                check("frame_spacing", starts_q[base+i] - starts_q[base+i-1], 10 * C);
            end
        end
        high_ok = 1;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) high_ok = 0;
        end
        check("frame_tx_idle_after", high_ok, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
